// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared parameters and FSM state type for the activation lane serializer
package act_pkg;

    localparam int LANES = 7;
    localparam int IW    = 32;
    localparam int OW    = 8;
    localparam int SHW   = 5;
    localparam int LW    = $clog2(LANES);

    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/act_requant.sv
// rtl/act_requant.sv - rounding arithmetic right shift with unsigned saturation of one lane
module act_requant
    import act_pkg::*;
(
    input  logic [IW-1:0]  x,
    input  logic [SHW-1:0] shift,
    output logic [OW-1:0]  y
);

    logic signed [IW:0] ext;
    logic signed [IW:0] rnd;
    logic signed [IW:0] sum;
    logic signed [IW:0] shifted;

    // One guard bit so that adding the half-LSB to a large positive value cannot wrap.
    always_comb begin
        ext     = {x[IW-1], x};
        rnd     = '0;
        if (shift != '0) begin
            rnd = (IW+1)'(1) << (shift - SHW'(1));
        end
        sum     = ext + rnd;
        shifted = sum >>> shift;
    end

    always_comb begin
        y = shifted[OW-1:0];
        if (shifted[IW]) begin
            y = '0;
        end else if (|shifted[IW-1:OW]) begin
            y = '1;
        end
    end

endmodule

// File: rtl/act_lane_serializer.sv
// rtl/act_lane_serializer.sv - holds one 7x32 activation block and drains it as requantised per-lane beats
module act_lane_serializer
    import act_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [LANES*IW-1:0] s_data,
    input  logic                s_last,
    input  logic [SHW-1:0]      s_shift,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [OW-1:0]       m_data,
    output logic [2:0]          m_lane,
    output logic                m_last,
    output logic                busy
);

    state_e         state_q, state_d;
    logic [LW-1:0]  lane_q, lane_d;
    logic [IW-1:0]  lanes_q [LANES];
    logic [SHW-1:0] shift_q;
    logic           last_q;
    logic           capture;
    logic           at_last_lane;
    logic [IW-1:0]  lane_word;

    assign at_last_lane = (lane_q == LAST_LANE);

    // m_ready -> s_ready is the only combinational path through the block.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        s_ready = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    capture = 1'b1;
                    lane_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                s_ready = at_last_lane && m_ready;
                if (m_ready) begin
                    if (!at_last_lane) begin
                        lane_d = lane_q + LW'(1);
                    end else if (s_valid) begin
                        capture = 1'b1;
                        lane_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (capture) begin
                shift_q <= s_shift;
                last_q  <= s_last;
                for (int i = 0; i < LANES; i++) begin
                    lanes_q[i] <= s_data[i*IW +: IW];
                end
            end
        end
    end

    always_comb begin
        lane_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
                lane_word = lanes_q[i];
            end
        end
    end

    act_requant u_requant (
        .x     (lane_word),
        .shift (shift_q),
        .y     (m_data)
    );

    assign m_valid = (state_q == SEND);
    assign busy    = (state_q == SEND);
    assign m_lane  = 3'(lane_q);
    assign m_last  = (state_q == SEND) && at_last_lane && last_q;

endmodule

// File: tb/tb_act_lane_serializer.sv
// tb/tb_act_lane_serializer.sv - scoreboard bench for act_lane_serializer
module tb_act_lane_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [223:0] s_data;
    logic         s_last;
    logic [4:0]   s_shift;
    logic         m_valid;
    logic         m_ready;
    logic [7:0]   m_data;
    logic [2:0]   m_lane;
    logic         m_last;
    logic         busy;

    typedef struct {
        logic [7:0] d;
        logic [2:0] lane;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    act_lane_serializer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_shift (s_shift),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_lane  (m_lane),
        .m_last  (m_last),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(input logic [31:0] x, input logic [4:0] sh);
        longint v;
        v = longint'(signed'(x));
        if (sh != 5'd0) begin
            v = (v + (longint'(1) << (sh - 1))) >>> sh;
        end
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    function automatic logic [223:0] pk(input logic [31:0] a, b, c, d, e, f, g);
        return {g, f, e, d, c, b, a};
    endfunction

    // Output monitor: pops the scoreboard on each handshake, checks holds and s_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_busy",    32'(busy),    32'd0);
            chk("rst_s_ready", 32'(s_ready), 32'd1);
            chk("rst_m_lane",  32'(m_lane),  32'd0);
            chk("rst_m_last",  32'(m_last),  32'd0);
        end else begin
            chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
            chk("busy",    32'(busy),    32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("m_data",  32'(m_data), 32'(q[0].d));
                chk("m_lane",  32'(m_lane), 32'(q[0].lane));
                chk("m_last",  32'(m_last), 32'(q[0].last));
                chk("s_ready", 32'(s_ready), 32'((q[0].lane == 3'd6) && m_ready));
                if (m_ready) void'(q.pop_front());
            end else begin
                chk("idle_s_ready", 32'(s_ready), 32'd1);
            end
        end
    end

    task automatic offer(input logic [223:0] d, input logic [4:0] sh, input logic lst);
        int  n;
        logic acc;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_shift = sh;
        s_last  = lst;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            if (acc) begin
                for (int i = 0; i < 7; i++) begin
                    q.push_back('{ref_q(d[i*32 +: 32], sh), 3'(i), lst && (i == 6)});
                end
                break;
            end
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        #1;
        s_valid = 1'b0;
        s_data  = {7{$urandom()}};
        s_shift = 5'($urandom_range(31, 0));
        s_last  = 1'($urandom_range(1, 0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_shift = '0;
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        offer(pk(10, 20, 30, 40, 50, 60, 70), 5'd0, 1'b1);
        drain();

        offer(pk(32'h180, 32'h17F, 32'h0, 32'h7F, 32'hFFFFFF80, 32'h100, 32'hFFFF), 5'd8, 1'b0);
        drain();
        offer(pk(32'h10000, 32'h7, 32'h8, 32'hFF0, 32'hFFFFFFF8, 32'h17, 32'h18), 5'd4, 1'b1);
        drain();
        offer(pk(32'hFFFFFFF0, 32'hFF, 32'h100, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h1), 5'd0, 1'b0);
        drain();
        offer(pk(32'h7FFFFFFF, 32'h80000000, 32'h40000000, 32'h3FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hC0000000), 5'd31, 1'b1);
        drain();

        // Backpressure on lane 2 for three cycles.
        offer(pk(1, 2, 3, 4, 5, 6, 7), 5'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();

        // Back-to-back blocks with s_valid held.
        offer(pk(100, 101, 102, 103, 104, 105, 106), 5'd0, 1'b0);
        offer(pk(32'h200, 32'h280, 32'h300, 32'h380, 32'h400, 32'h480, 32'h500), 5'd2, 1'b1);
        drain();

        // Reset while lane 3 is presented.
        offer(pk(11, 12, 13, 14, 15, 16, 17), 5'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        offer(pk(21, 22, 23, 24, 25, 26, 27), 5'd1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
